// File: rtl/muon_pkg.sv
// Shared types and helpers for the muon decay timer.
package muon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT2,
    ST_HOLDOFF
  } state_e;

  localparam int DT_W_DEF  = 16;
  localparam int CNT_W_DEF = 32;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? top : v + 64'd1;
  endfunction

endpackage

// File: rtl/muon_decay_timer_rise_detect.sv
// Registers the trigger level and flags its low-to-high transition.
module rise_detect (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;

  assign d_d  = d;
  assign rise = d & ~d_q;

  always_ff @(posedge clk) begin
    if (!rstn) d_q <= 1'b0;
    else       d_q <= d_d;
  end

endmodule

// File: rtl/muon_decay_timer.sv
// Measures the interval between a stopping-muon pulse and its decay pulse.
// Optional first-pulse peak capture is built when MUON_PEAK_CAPTURE_EN is defined.
module muon_decay_timer
  import muon_pkg::*;
#(
  parameter int DT_W    = DT_W_DEF,
  parameter int HOLDOFF = 64,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             adc_clk,
  input  logic             adc_rstn,
  input  logic             enable,
  input  logic             trig_edge,
  input  logic             trig_in,
  input  logic [13:0]      adc_dat_in,
  input  logic [DT_W-1:0]  window,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [DT_W-1:0]  event_dt,
  output logic [13:0]      event_peak,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  state_e            state_q, state_d;
  logic [DT_W-1:0]   cnt_q, cnt_d, win_eff;
  logic              valid_q, valid_d;
  logic [DT_W-1:0]   dt_q, dt_d;
  logic [CNT_W-1:0]  single_q, single_d, drop_q, drop_d;
  logic              rise, emit, load;

  rise_detect u_rise (
    .clk  (adc_clk),
    .rstn (adc_rstn),
    .d    (trig_in),
    .rise (rise)
  );

  assign win_eff = (window < DT_W'(2)) ? DT_W'(2) : window;

  // cnt is the interval in WAIT2 and the dead-time counter in HOLDOFF.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    emit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && rise) begin
          state_d = ST_WAIT2;
          cnt_d   = DT_W'(1);
        end
      end
      ST_WAIT2: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          emit    = 1'b1;
          state_d = ST_HOLDOFF;
          cnt_d   = DT_W'(1);
        end else if (cnt_q >= win_eff) begin
          single_d = CNT_W'(sat_inc(64'(single_q), CNT_W));
          state_d  = ST_HOLDOFF;
          cnt_d    = DT_W'(1);
        end else begin
          cnt_d = cnt_q + DT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (!enable || cnt_q >= DT_W'(HOLDOFF)) state_d = ST_IDLE;
        else                                     cnt_d   = cnt_q + DT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A result arriving while the previous one is still unread is lost.
  assign load = emit && (!valid_q || event_ready);

  always_comb begin
    valid_d = valid_q;
    dt_d    = dt_q;
    drop_d  = drop_q;
    if (load) begin
      valid_d = 1'b1;
      dt_d    = cnt_q;
    end else if (emit) begin
      drop_d = CNT_W'(sat_inc(64'(drop_q), CNT_W));
    end else if (valid_q && event_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      dt_q     <= '0;
      single_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      dt_q     <= dt_d;
      single_q <= single_d;
      drop_q   <= drop_d;
    end
  end

  assign event_valid = valid_q;
  assign event_dt    = dt_q;
  assign single_cnt  = single_q;
  assign drop_cnt    = drop_q;

`ifdef MUON_PEAK_CAPTURE_EN
  logic [13:0] peak_q, peak_d, epk_q, epk_d;
  logic        trk_q, trk_d;

  // Track the extreme sample only while the first pulse is still above threshold.
  always_comb begin
    peak_d = peak_q;
    trk_d  = trk_q;
    epk_d  = load ? peak_q : epk_q;
    if (state_q == ST_IDLE && enable && rise) begin
      peak_d = adc_dat_in;
      trk_d  = 1'b1;
    end else if (state_q == ST_WAIT2 && trk_q) begin
      if (!trig_in)                              trk_d  = 1'b0;
      else if (!trig_edge && adc_dat_in > peak_q) peak_d = adc_dat_in;
      else if (trig_edge && adc_dat_in < peak_q)  peak_d = adc_dat_in;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      peak_q <= '0;
      trk_q  <= 1'b0;
      epk_q  <= '0;
    end else begin
      peak_q <= peak_d;
      trk_q  <= trk_d;
      epk_q  <= epk_d;
    end
  end

  assign event_peak = epk_q;
`else
  logic unused_peak_inputs;
  assign unused_peak_inputs = trig_edge ^ (^adc_dat_in);
  assign event_peak         = '0;
`endif

endmodule

// File: tb/tb_muon_decay_timer.sv
// Directed and randomized checks of muon_decay_timer against a timestamp-based model.
module tb_muon_decay_timer;

  localparam int DT_W    = 16;
  localparam int CNT_W   = 32;
  localparam int HOLDOFF = 64;
  localparam longint MAXC = longint'((64'd1 << CNT_W) - 64'd1);
`ifdef MUON_PEAK_CAPTURE_EN
  localparam bit PK_ON = 1'b1;
`else
  localparam bit PK_ON = 1'b0;
`endif

  logic             adc_clk = 1'b0;
  logic             adc_rstn = 1'b0;
  logic             enable = 1'b0;
  logic             trig_edge = 1'b0;
  logic             trig_in = 1'b0;
  logic [13:0]      adc_dat_in = '0;
  logic [DT_W-1:0]  window = DT_W'(100);
  logic             event_ready = 1'b1;
  logic             event_valid;
  logic [DT_W-1:0]  event_dt;
  logic [13:0]      event_peak;
  logic [CNT_W-1:0] single_cnt, drop_cnt;

  muon_decay_timer #(.DT_W(DT_W), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .adc_clk     (adc_clk),
    .adc_rstn    (adc_rstn),
    .enable      (enable),
    .trig_edge   (trig_edge),
    .trig_in     (trig_in),
    .adc_dat_in  (adc_dat_in),
    .window      (window),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_dt    (event_dt),
    .event_peak  (event_peak),
    .single_cnt  (single_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a measurement is "armed" with its start timestamp; dead time is an end timestamp.
  int     m_cyc = 0;
  int     m_armed = -1;
  int     m_dead = -1;
  bit     m_trd = 1'b0;
  bit     m_trk = 1'b0;
  int     m_pk = 0;
  bit     e_v = 1'b0;
  longint e_dt = 0, e_pk = 0, e_single = 0, e_drop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model();
    bit rise, emit;
    int weff, dt, nd_dt, nd_pk, smp;
    emit = 1'b0; nd_dt = 0; nd_pk = 0;
    if (!adc_rstn) begin
      m_trd = 1'b0; m_armed = -1; m_dead = -1; m_trk = 1'b0;
      e_v = 1'b0; e_dt = 0; e_pk = 0; e_single = 0; e_drop = 0;
    end else begin
      rise = trig_in && !m_trd;
      weff = (window < 2) ? 2 : int'(window);
      smp  = int'(adc_dat_in);
      if (!enable) begin
        m_armed = -1;
        m_dead  = m_cyc;
      end else if (m_armed >= 0) begin
        if (m_trk) begin
          if (!trig_in) m_trk = 1'b0;
          else if (trig_edge) m_pk = (smp < m_pk) ? smp : m_pk;
          else                m_pk = (smp > m_pk) ? smp : m_pk;
        end
        dt = m_cyc - m_armed;
        if (rise) begin
          emit = 1'b1; nd_dt = dt; nd_pk = m_pk;
          m_armed = -1; m_dead = m_cyc + HOLDOFF;
        end else if (dt >= weff) begin
          e_single = (e_single == MAXC) ? MAXC : e_single + 1;
          m_armed = -1; m_dead = m_cyc + HOLDOFF;
        end
      end else if (m_cyc > m_dead && rise) begin
        m_armed = m_cyc; m_pk = smp; m_trk = 1'b1;
      end
      if (emit) begin
        if (!e_v || event_ready) begin
          e_v = 1'b1; e_dt = nd_dt; e_pk = PK_ON ? nd_pk : 0;
        end else begin
          e_drop = (e_drop == MAXC) ? MAXC : e_drop + 1;
        end
      end else if (e_v && event_ready) begin
        e_v = 1'b0;
      end
      m_trd = trig_in;
    end
    m_cyc++;
  endtask

  task automatic step();
    @(posedge adc_clk);
    model();
    #1;
    chk("valid",  64'(event_valid), 64'(e_v));
    chk("dt",     64'(event_dt),    64'(e_dt));
    chk("peak",   64'(event_peak),  64'(e_pk));
    chk("single", 64'(single_cnt),  64'(e_single));
    chk("drop",   64'(drop_cnt),    64'(e_drop));
  endtask

  // Single-cycle pulses at relative cycles a and b (negative = none).
  task automatic pat(input int len, input int a, input int b);
    for (int s = 0; s < len; s++) begin
      trig_in    = (s == a) || (s == b);
      adc_dat_in = 14'($urandom);
      step();
    end
  endtask

  int wins[7] = '{0, 1, 2, 3, 7, 15, 30};

  initial begin
    adc_rstn = 1'b0;
    step(); step();
    chk("rst_valid", 64'(event_valid), 64'd0);
    chk("rst_single", 64'(single_cnt), 64'd0);
    adc_rstn = 1'b1; enable = 1'b1; window = DT_W'(100); trig_edge = 1'b0;

    // Pair at t1=10, t2=47 with a three-sample first pulse.
    for (int s = 0; s < 48; s++) begin
      trig_in    = (s >= 10 && s <= 12) || s == 47;
      adc_dat_in = (s == 10) ? 14'd500 : (s == 11) ? 14'd900 : (s == 12) ? 14'd700 : 14'd300;
      step();
      if (s == 46) chk("pair_early", 64'(event_valid), 64'd0);
    end
    chk("pair_valid", 64'(event_valid), 64'd1);
    chk("pair_dt", 64'(event_dt), 64'd37);
    chk("pair_peak", 64'(event_peak), PK_ON ? 64'd900 : 64'd0);
    chk("pair_single", 64'(single_cnt), 64'd0);
    pat(80, -1, -1);

    // Lone pulse times out; a pulse during dead time is ignored.
    window = DT_W'(20);
    pat(30, 10, -1);
    chk("to_before", 64'(single_cnt), 64'd0);
    pat(1, -1, -1);
    chk("to_after", 64'(single_cnt), 64'd1);
    pat(20, 5, -1);
    chk("hold_valid", 64'(event_valid), 64'd0);
    chk("hold_single", 64'(single_cnt), 64'd1);
    pat(70, -1, -1);

    // Second pulse exactly at the window edge wins over the timeout.
    pat(31, 10, 30);
    chk("edge_valid", 64'(event_valid), 64'd1);
    chk("edge_dt", 64'(event_dt), 64'd20);
    chk("edge_single", 64'(single_cnt), 64'd1);
    pat(80, -1, -1);

    // Back-pressure: second result dropped, first held.
    event_ready = 1'b0;
    pat(16, 10, 15);
    pat(100, 80, 88);
    chk("bp_valid", 64'(event_valid), 64'd1);
    chk("bp_dt", 64'(event_dt), 64'd5);
    chk("bp_drop", 64'(drop_cnt), 64'd1);
    event_ready = 1'b1;
    pat(1, -1, -1);
    chk("bp_clear", 64'(event_valid), 64'd0);
    pat(70, -1, -1);

    // Reset in WAIT2.
    pat(15, 10, -1);
    adc_rstn = 1'b0;
    pat(1, -1, -1);
    chk("mrst_drop", 64'(drop_cnt), 64'd0);
    chk("mrst_single", 64'(single_cnt), 64'd0);
    chk("mrst_dt", 64'(event_dt), 64'd0);
    adc_rstn = 1'b1;
    pat(40, -1, -1);
    chk("mrst_nosingle", 64'(single_cnt), 64'd0);

    // Enable dropped in WAIT2.
    pat(15, 10, -1);
    enable = 1'b0;
    pat(1, -1, -1);
    enable = 1'b1;
    pat(40, -1, -1);
    chk("en_single", 64'(single_cnt), 64'd0);
    chk("en_valid", 64'(event_valid), 64'd0);

    // Randomized phases; window and polarity change only while disabled.
    for (int ph = 0; ph < 20; ph++) begin
      enable = 1'b0; adc_rstn = 1'b1;
      step();
      window    = DT_W'(wins[$urandom_range(0, 6)]);
      trig_edge = 1'($urandom_range(0, 1));
      step();
      for (int c = 0; c < 300; c++) begin
        trig_in     = trig_in ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
        adc_dat_in  = 14'($urandom);
        event_ready = ($urandom_range(0, 3) != 0);
        enable      = ($urandom_range(0, 199) != 0);
        adc_rstn    = ($urandom_range(0, 499) != 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muon_decay_timer.md
# muon_decay_timer

Downstream of the single-pulse trigger comparator: consumes its per-sample trigger level and registered ADC data, finds the first pulse (muon stop) and a second pulse (decay electron) within a programmable window, and reports the inter-pulse interval in ADC clock cycles. Each result is presented through a one-entry valid/ready output register to the readout/histogram logic. Pulses with no partner inside the window are counted as singles.

## Interface
- DT_W, 16: width of interval counter, `window` and `event_dt`
- HOLDOFF, 64: dead-time cycles after each accepted event or timeout
- CNT_W, 32: width of `single_cnt` and `drop_cnt`

- adc_clk  in  1  ADC sample clock; sole clock
- adc_rstn  in  1  reset, synchronous, active-low
- enable  in  1  measurement enable
- trig_edge  in  1  polarity, same meaning as the comparator's (0: pulse above threshold, 1: below)
- trig_in  in  1  comparator trigger level
- adc_dat_in  in  14  comparator's registered ADC data, unsigned
- window  in  DT_W  max accepted interval; values <2 treated as 2
- event_valid  out  1  result pending
- event_ready  in  1  consumer accepts result
- event_dt  out  DT_W  interval t2−t1 in cycles
- event_peak  out  14  extreme sample of first pulse
- single_cnt  out  CNT_W  timeouts, saturating
- drop_cnt  out  CNT_W  results lost to back-pressure, saturating

## Operation
- `trig_d` register; rise = trig_in & ~trig_d. Rising edges only, so a second pulse requires trig_in to have dropped.
- States: IDLE, WAIT2, HOLDOFF.
- IDLE: on rise & enable → WAIT2, cnt ← 1 next cycle (rise cycle = t1, cnt counts cycles elapsed since t1).
- WAIT2: cnt increments each cycle. rise with cnt ≤ window → emit dt = cnt, → HOLDOFF. cnt == window without rise → single_cnt+1, → HOLDOFF. rise on the cycle where cnt == window: event wins, no single counted.
- HOLDOFF: HOLDOFF cycles, rises ignored, then → IDLE. Rise on the IDLE-entry cycle is accepted.
- enable low in any state: → IDLE next cycle, no counters touched; pending output unaffected.
- Output register: loads on emit when !event_valid or event_ready same cycle; else result dropped, drop_cnt+1, register unchanged.
- event_valid clears on valid & ready unless simultaneously reloaded.
- Counters saturate at all-ones.

## Timing
- Reset values: event_valid 0, event_dt 0, event_peak 0, single_cnt 0, drop_cnt 0; state IDLE, trig_d 0.
- Second rise at cycle t2 → event_valid high at t2+1 with event_dt = t2−t1.
- Timeout registered: single_cnt updates the cycle after cnt == window.
- Minimum measurable dt is 2 (one low cycle between pulses).
- Reset asserted mid-measurement: all state/outputs to reset values on the next edge; no event or single emitted.
- `window` and `trig_edge` sampled continuously; change only in IDLE.

## Configuration
- MUON_PEAK_CAPTURE_EN defined: from t1 while trig_in stays high, track max (trig_edge = 0) or min (trig_edge = 1) of adc_dat_in. Reload at t1 with that cycle's sample; latch into event_peak with event_dt.
- Undefined: no tracking logic; event_peak tied to 0.

## Structure
- Package muon_pkg: state enum (IDLE, WAIT2, HOLDOFF), default DT_W/CNT_W constants, saturating-increment function.
- Sub-module rise_detect: trig_d register plus rise output, reset to 0.

## Test plan
- window = 100, HOLDOFF = 64; rises at t1 = 10, t2 = 47 → one event, event_dt = 37, valid at cycle 48, single_cnt = 0.
- Single pulse, window = 20 → single_cnt = 1 at t1+21, no event_valid; second pulse during HOLDOFF → ignored.
- Second rise at exactly t1+window (window = 20) → event_dt = 20, single_cnt unchanged.
- event_ready held low, two decay pairs → first result held (dt unchanged), drop_cnt = 1; ready high → valid clears next cycle.
- MUON_PEAK_CAPTURE_EN, trig_edge = 0, first-pulse samples 500, 900, 700 → event_peak = 900; macro off → 0.
- adc_rstn low in WAIT2 and enable low in WAIT2 → IDLE, no event, counters as specified (reset: zero; enable: unchanged).
